arbiter_4_deq: RTL and testbench
================================

Name: arbiter_4_deq

Overview:
- Transmit-side counterpart of the ring node's enqueue router.
- Drains the four node FIFOs: pass req, pass rep, local-out req, local-out rep.
- Merges them onto the single ring output link with message-level locking (head..tail never interleaved) and round-robin fairness between messages.
- Output is registered, with valid/ready backpressure from the downstream link.

Parameters:
FLIT_W, 16, flit payload width
CTRL_W, 2, flit control width (fixed encoding, see package)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pass_req_valid  in  1  pass req FIFO non-empty
pass_req_flit  in  16  pass req FIFO head flit
pass_req_ctrl  in  2  pass req FIFO head ctrl
pass_req_deq  out  1  pop pass req FIFO (one-cycle pulse per flit)
pass_rep_valid/_flit/_ctrl/_deq  same as above, pass rep FIFO
local_out_req_valid/_flit/_ctrl/_deq  same, local-out req FIFO
local_out_rep_valid/_flit/_ctrl/_deq  same, local-out rep FIFO
out_ready  in  1  downstream link can accept a flit this cycle
out_valid  out  1  out_flit/out_ctrl valid
out_flit  out  16  flit to ring
out_ctrl  out  2  ctrl to ring
out_src  out  2  source of current out flit: 00 pass req, 01 pass rep, 10 local req, 11 local rep
busy  out  1  state==LOCKED
proto_err  out  1  sticky protocol-error flag, cleared only by rst

Behaviour:
- Ctrl encoding: 00 idle/invalid, 01 head, 10 body, 11 tail. A single-flit message is one flit with ctrl 11.
- Reset (rst high at clk edge): out_valid=0, out_flit=0, out_ctrl=0, out_src=0, proto_err=0, state=IDLE, rr_ptr=0. All *_deq are 0 while rst is high.
- space = !out_valid || out_ready.
- load = space && grant. When load: the granted *_deq pulses combinationally in that cycle; out_* register the flit at the next edge (1-cycle latency from deq to out_valid).
- At most one *_deq is high per cycle.
- If out_valid && out_ready && !load: out_valid drops to 0 next edge.
- While out_valid && !out_ready: out_flit, out_ctrl and out_src hold stable; no deq.
- IDLE:
  - Scan sources starting at rr_ptr, wrapping 3->0; pick the first with valid=1.
  - Picked ctrl=01: load, state->LOCKED, sel=picked.
  - Picked ctrl=11: load, stay IDLE, rr_ptr=picked+1 mod 4.
  - Picked ctrl=10 or 00: set proto_err, pulse deq to discard (no space required, no load), rr_ptr unchanged.
- LOCKED:
  - Only source sel is eligible; all others are ignored even if valid.
  - sel valid=0 (gap): wait; stay LOCKED.
  - ctrl=10: load.
  - ctrl=11: load, state->IDLE, rr_ptr=sel+1 mod 4.
  - ctrl=01: set proto_err, load anyway, stay LOCKED.
  - ctrl=00: set proto_err, discard via deq.
- Simultaneous events: an out register drain and a new load in the same cycle are allowed (back-to-back flits at full rate).
- rst mid-message: lock is abandoned immediately. Upstream FIFOs are reset in the same cycle; truncation downstream is acceptable.

Decomposition:
- Shared package/include holds:
  - ctrl constants CTRL_IDLE/HEAD/BODY/TAIL;
  - source index constants SRC_PASS_REQ=0, SRC_PASS_REP=1, SRC_LOCAL_REQ=2, SRC_LOCAL_REP=3 (same numbering as the enqueue dest_fifo field);
  - state encoding IDLE/LOCKED.
- One sub-module, rr_pick4: combinational 4-way rotating-priority picker. Inputs: 4-bit request, 2-bit pointer. Outputs: found, 2-bit index.

Test Plan:
- pass_req holds 3-flit msg (01 A0, 10 A1, 11 A2), out_ready=1 -> pass_req_deq high 3 consecutive cycles; out_valid high the following 3 cycles with A0/A1/A2, out_src=00; state returns to IDLE, rr_ptr=1.
- All four sources continuously valid with single-flit msgs (ctrl 11), rr_ptr=0 -> grant order 00,01,10,11,00,01; one flit per cycle.
- pass_rep sends head; local_out_req is valid throughout; pass_rep_valid drops for 2 cycles mid-message -> local_out_req_deq stays 0 until the cycle after pass_rep tail is dequeued; busy=1 throughout.
- out_valid=1 with out_ready=0 for 3 cycles -> out_flit/out_ctrl stable, all deq 0; out_ready=1 -> next flit loaded the same cycle, no bubble.
- IDLE with local_out_rep head ctrl=10 -> proto_err=1 (stays 1), local_out_rep_deq pulses once, out_valid unchanged, rr_ptr unchanged.
- rst asserted while LOCKED mid-message -> after the edge all outputs 0, busy=0; a subsequent head on pass_req is granted with out_src=00.

Source files
------------

// File: rtl/arbiter_4_deq_pkg.sv
// arbiter_4_deq_pkg: shared ctrl, source and state encodings for the ring transmit arbiter
package arbiter_4_deq_pkg;
  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;
  localparam logic [1:0] SRC_PASS_REQ  = 2'd0;
  localparam logic [1:0] SRC_PASS_REP  = 2'd1;
  localparam logic [1:0] SRC_LOCAL_REQ = 2'd2;
  localparam logic [1:0] SRC_LOCAL_REP = 2'd3;
  typedef enum logic {IDLE, LOCKED} state_e;
endpackage

// File: rtl/arbiter_4_deq_rr_pick4.sv
// rr_pick4: 4-way rotating-priority picker, first request at or after ptr_i wins
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       found_o,
  output logic [1:0] idx_o
);
  assign found_o = |req_i;
  // Scan from farthest to nearest so the closest requester overwrites last.
  always_comb begin
    idx_o = ptr_i;
    for (int i = 3; i >= 0; i--) if (req_i[ptr_i + 2'(i)]) idx_o = ptr_i + 2'(i);
  end
endmodule

// File: rtl/arbiter_4_deq.sv
// arbiter_4_deq: merges four node FIFOs onto one ring link with message locking and round-robin
module arbiter_4_deq
  import arbiter_4_deq_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pass_req_valid,
  input  logic [FLIT_W-1:0] pass_req_flit,
  input  logic [CTRL_W-1:0] pass_req_ctrl,
  output logic              pass_req_deq,
  input  logic              pass_rep_valid,
  input  logic [FLIT_W-1:0] pass_rep_flit,
  input  logic [CTRL_W-1:0] pass_rep_ctrl,
  output logic              pass_rep_deq,
  input  logic              local_out_req_valid,
  input  logic [FLIT_W-1:0] local_out_req_flit,
  input  logic [CTRL_W-1:0] local_out_req_ctrl,
  output logic              local_out_req_deq,
  input  logic              local_out_rep_valid,
  input  logic [FLIT_W-1:0] local_out_rep_flit,
  input  logic [CTRL_W-1:0] local_out_rep_ctrl,
  output logic              local_out_rep_deq,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        out_src,
  output logic              busy,
  output logic              proto_err
);
  state_e state_q, state_d;
  logic [1:0] rr_q, rr_d, sel_q, sel_d, pick, src;
  logic [3:0] vld, deq;
  logic [FLIT_W-1:0] flit [4];
  logic [CTRL_W-1:0] ctrl [4];
  logic [CTRL_W-1:0] c;
  logic found, act, space, load, drop, err_set;
  logic out_valid_q, err_q;
  logic [FLIT_W-1:0] out_flit_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [1:0] out_src_q;
  assign vld  = {local_out_rep_valid, local_out_req_valid, pass_rep_valid, pass_req_valid};
  assign flit = '{pass_req_flit, pass_rep_flit, local_out_req_flit, local_out_rep_flit};
  assign ctrl = '{pass_req_ctrl, pass_rep_ctrl, local_out_req_ctrl, local_out_rep_ctrl};
  rr_pick4 u_pick (.req_i(vld), .ptr_i(rr_q), .found_o(found), .idx_o(pick));
  assign space = !out_valid_q || out_ready;
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    load    = 1'b0;
    drop    = 1'b0;
    err_set = 1'b0;
    src     = (state_q == LOCKED) ? sel_q : pick;
    act     = (state_q == LOCKED) ? vld[sel_q] : found;
    c       = ctrl[src];
    if (act) begin
      if (state_q == IDLE) begin
        if (c == CTRL_HEAD || c == CTRL_TAIL) begin
          load = space;
          if (space && c == CTRL_HEAD) begin
            state_d = LOCKED;
            sel_d   = src;
          end
          if (space && c == CTRL_TAIL) rr_d = src + 2'd1;
        end else begin
          drop    = 1'b1;
          err_set = 1'b1;
        end
      end else if (c == CTRL_IDLE) begin
        drop    = 1'b1;
        err_set = 1'b1;
      end else begin
        load    = space;
        err_set = (c == CTRL_HEAD);
        if (space && c == CTRL_TAIL) begin
          state_d = IDLE;
          rr_d    = src + 2'd1;
        end
      end
    end
    deq = (!rst && (load || drop)) ? 4'b0001 << src : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 2'd0;
      sel_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_ctrl_q  <= '0;
      out_src_q   <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      err_q   <= err_q | err_set;
      if (load) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= flit[src];
        out_ctrl_q  <= c;
        out_src_q   <= src;
      end else if (out_ready) out_valid_q <= 1'b0;
    end
  end
  assign {local_out_rep_deq, local_out_req_deq, pass_rep_deq, pass_req_deq} = deq;
  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == LOCKED);
  assign proto_err = err_q;
endmodule

// File: tb/tb_arbiter_4_deq.sv
// tb_arbiter_4_deq: FIFO-model stimulus with a scoreboard monitor on the output link
module tb_arbiter_4_deq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;
  logic [3:0] vld = 4'd0;
  logic [15:0] fl [4] = '{default: '0};
  logic [1:0] ct [4] = '{default: '0};
  logic [3:0] deq, d_s;
  logic rst_s;
  logic out_valid, busy, proto_err;
  logic [15:0] out_flit;
  logic [1:0] out_ctrl, out_src;
  logic pr_deq, pp_deq, lq_deq, lp_deq;
  logic [17:0] q0 [$];
  logic [17:0] q1 [$];
  logic [17:0] q2 [$];
  logic [17:0] q3 [$];
  logic [19:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  localparam logic [1:0] T2 [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  localparam logic [3:0] D3 [6] = '{4'd2, 4'd0, 4'd0, 4'd2, 4'd2, 4'd4};
  localparam logic       B3 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [3:0] D4 [6] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};

  arbiter_4_deq #(.FLIT_W(16), .CTRL_W(2)) dut (
    .clk(clk), .rst(rst),
    .pass_req_valid(vld[0]), .pass_req_flit(fl[0]), .pass_req_ctrl(ct[0]), .pass_req_deq(pr_deq),
    .pass_rep_valid(vld[1]), .pass_rep_flit(fl[1]), .pass_rep_ctrl(ct[1]), .pass_rep_deq(pp_deq),
    .local_out_req_valid(vld[2]), .local_out_req_flit(fl[2]), .local_out_req_ctrl(ct[2]),
    .local_out_req_deq(lq_deq),
    .local_out_rep_valid(vld[3]), .local_out_rep_flit(fl[3]), .local_out_rep_ctrl(ct[3]),
    .local_out_rep_deq(lp_deq),
    .out_ready(out_ready), .out_valid(out_valid), .out_flit(out_flit), .out_ctrl(out_ctrl),
    .out_src(out_src), .busy(busy), .proto_err(proto_err)
  );
  assign deq = {lp_deq, lq_deq, pp_deq, pr_deq};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    d_s   <= deq;
    rst_s <= rst;
  end

  // Upstream FIFO model: pop after the edge that consumed a deq, present new heads a little later.
  always begin
    @(posedge clk);
    #1;
    if (rst_s) begin
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
    end else begin
      if (d_s[0]) void'(q0.pop_front());
      if (d_s[1]) void'(q1.pop_front());
      if (d_s[2]) void'(q2.pop_front());
      if (d_s[3]) void'(q3.pop_front());
    end
    #2;
    vld[0] = q0.size() != 0; {ct[0], fl[0]} = vld[0] ? q0[0] : 18'd0;
    vld[1] = q1.size() != 0; {ct[1], fl[1]} = vld[1] ? q1[0] : 18'd0;
    vld[2] = q2.size() != 0; {ct[2], fl[2]} = vld[2] ? q2[0] : 18'd0;
    vld[3] = q3.size() != 0; {ct[3], fl[3]} = vld[3] ? q3[0] : 18'd0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [1:0] c, input logic [15:0] f);
    case (s)
      2'd0: q0.push_back({c, f});
      2'd1: q1.push_back({c, f});
      2'd2: q2.push_back({c, f});
      default: q3.push_back({c, f});
    endcase
  endtask

  task automatic ex(input logic [1:0] s, input logic [1:0] c, input logic [15:0] f);
    exp_q.push_back({s, c, f});
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got %h with nothing expected", {out_src, out_ctrl, out_flit});
          end else chk("out_msg", {12'd0, out_src, out_ctrl, out_flit}, {12'd0, exp_q.pop_front()});
        end
      end
    join_none
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_flit", out_flit, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_src", out_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_deq", deq, 0);
    tick(); rst = 1'b0; tick();
    // three-flit message from pass req
    push(0, 2'b01, 16'hA000); push(0, 2'b10, 16'hA001); push(0, 2'b11, 16'hA002);
    ex(0, 2'b01, 16'hA000); ex(0, 2'b10, 16'hA001); ex(0, 2'b11, 16'hA002);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_deq", deq, (i < 3) ? 1 : 0);
      chk("t1_busy", busy, (i == 1 || i == 2) ? 1 : 0);
      if (i == 1) chk("t1_first", {out_valid, out_flit}, {1'b1, 16'hA000});
      tick();
    end
    repeat (2) tick();
    // all sources busy with single-flit messages, rr_ptr left at 1 by the previous tail
    for (int n = 0; n < 2; n++)
      for (int s = 0; s < 4; s++) push(2'(s), 2'b11, 16'hB000 + 16'(s * 16 + n));
    for (int i = 0; i < 8; i++) ex(T2[i], 2'b11, 16'hB000 + 16'(T2[i]) * 16 + 16'(i / 4));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_deq", deq, 4'b0001 << T2[i]);
      tick();
    end
    @(negedge clk);
    chk("t2_idle_deq", deq, 0);
    repeat (2) tick();
    // locked pass rep message with a 2-cycle gap while local req waits
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        push(1, 2'b01, 16'hC000); push(2, 2'b11, 16'hC200);
        ex(1, 2'b01, 16'hC000);
      end
      if (i == 3) begin
        push(1, 2'b10, 16'hC001); push(1, 2'b11, 16'hC002);
        ex(1, 2'b10, 16'hC001); ex(1, 2'b11, 16'hC002); ex(2, 2'b11, 16'hC200);
      end
      @(negedge clk);
      chk("t3_deq", deq, D3[i]);
      chk("t3_busy", busy, B3[i]);
      tick();
    end
    repeat (2) tick();
    // backpressure: output held for 3 cycles, then next flit loads with no bubble
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        out_ready = 1'b0;
        push(0, 2'b11, 16'hD000); push(0, 2'b11, 16'hD001);
        ex(0, 2'b11, 16'hD000); ex(0, 2'b11, 16'hD001);
      end
      if (i == 4) out_ready = 1'b1;
      @(negedge clk);
      chk("t4_deq", deq, D4[i]);
      if (i > 0) chk("t4_out", {out_valid, out_ctrl, out_flit}, {1'b1, 2'b11, (i == 5) ? 16'hD001 : 16'hD000});
      tick();
    end
    repeat (2) tick();
    // body flit while idle is discarded and flagged
    push(3, 2'b10, 16'hE300);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_deq", deq, (i == 0) ? 8 : 0);
      chk("t5_err", proto_err, (i == 0) ? 0 : 1);
      chk("t5_valid", out_valid, 0);
      tick();
    end
    push(0, 2'b11, 16'hE000); push(1, 2'b11, 16'hE100);
    ex(1, 2'b11, 16'hE100); ex(0, 2'b11, 16'hE000);
    @(negedge clk); chk("t5_rr_first", deq, 2); tick();
    @(negedge clk); chk("t5_rr_second", deq, 1); tick();
    repeat (2) tick();
    // reset in the middle of a locked message
    push(0, 2'b01, 16'hF000); ex(0, 2'b01, 16'hF000);
    @(negedge clk); chk("t6_head_deq", deq, 1); tick();
    @(negedge clk); chk("t6_busy", busy, 1); tick();
    rst = 1'b1;
    push(0, 2'b10, 16'hF001);
    @(negedge clk); chk("t6_rst_deq", deq, 0); tick();
    @(negedge clk);
    chk("t6_rst_out", {out_valid, out_ctrl, out_src, out_flit}, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", proto_err, 0);
    tick();
    rst = 1'b0;
    push(0, 2'b01, 16'hF100); push(0, 2'b11, 16'hF101); push(1, 2'b11, 16'hF110);
    ex(0, 2'b01, 16'hF100); ex(0, 2'b11, 16'hF101); ex(1, 2'b11, 16'hF110);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_deq", deq, (i == 2) ? 2 : 1);
      tick();
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
